// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with 2-of-3 mid-bit voting, optional parity and stop check.
// Latency: result pulse (1 + P_data_width + PAR_EN)*16*OS_TICKS + 10*OS_TICKS clocks after start-edge detection.
// Backpressure: none; results are one-cycle strobes and P_DATA holds the last good word.
//
// Ports:
//   CLK        master clock, rising edge
//   RST        asynchronous active-high reset
//   RX_IN      serial line (idle high, LSB first), asynchronous to CLK
//   PAR_EN     parity bit present in the frame
//   PAR_TYP    0 = even parity, 1 = odd parity
//   P_DATA     last correctly received word
//   DATA_VALID one-cycle strobe when P_DATA is updated
//   PAR_ERR    one-cycle strobe on parity mismatch
//   STOP_ERR   one-cycle strobe when the stop bit is sampled low
//   Busy       high while a frame is being received
module uart_rx #(
  parameter int CLK_freq     = 100_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int P_data_width = 8,
  // Derived from the clock and baud rate; must evaluate to at least 1.
  parameter int OS_TICKS     = CLK_freq / (BAUD_RATE * 16)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RX_IN,
  input  logic                    PAR_EN,
  input  logic                    PAR_TYP,
  output logic [P_data_width-1:0] P_DATA,
  output logic                    DATA_VALID,
  output logic                    PAR_ERR,
  output logic                    STOP_ERR,
  output logic                    Busy
);

  localparam int PW = (OS_TICKS > 1) ? $clog2(OS_TICKS) : 1;
  localparam int BW = (P_data_width > 1) ? $clog2(P_data_width) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(OS_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(P_data_width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state, next_state;

  // Synchronizer; preset to the idle level so reset release never looks like a start edge.
  logic rx_meta, rx_s, rx_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Prescaler and 16-phase sample counter.
  logic [PW-1:0] presc;
  logic [3:0]    s_cnt;
  logic          tick;
  logic          start_det;
  logic          mid_tick;
  logic          end_tick;

  assign tick      = (presc == PRESC_LAST);
  assign start_det = (state == IDLE) && rx_d && !rx_s;
  assign mid_tick  = tick && (s_cnt == 4'd9);
  assign end_tick  = tick && (s_cnt == 4'd15);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc <= '0;
      s_cnt <= 4'd0;
    end else if (start_det) begin
      presc <= '0;
      s_cnt <= 4'd0;
    end else if (tick) begin
      presc <= '0;
      s_cnt <= s_cnt + 4'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Samples at counts 7 and 8 are stored; the count-9 sample is the live rx_s,
  // so the vote is available on the count-9 tick itself.
  logic smp7, smp8, maj, bit_val;

  assign maj = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      smp7    <= 1'b1;
      smp8    <= 1'b1;
      bit_val <= 1'b1;
    end else begin
      if (tick && (s_cnt == 4'd7)) smp7 <= rx_s;
      if (tick && (s_cnt == 4'd8)) smp8 <= rx_s;
      if (mid_tick)                bit_val <= maj;
    end
  end

  // Frame datapath.
  logic [P_data_width-1:0] shreg, shreg_nxt;
  logic [BW-1:0]           bit_idx;
  logic                    par_en_l, par_typ_l, par_bad, par_exp;
  logic                    ld_cfg, shift_en, par_chk;
  logic                    dv_set, pe_set, se_set;

  // Wire order is LSB first, so each new bit enters at the MSB and the word
  // is aligned once all data bits have been shifted in.
  always_comb begin
    shreg_nxt = shreg;
    shreg_nxt[P_data_width-1] = bit_val;
    for (int i = 0; i < P_data_width - 1; i++) begin
      shreg_nxt[i] = shreg[i+1];
    end
  end

  assign par_exp = par_typ_l ? ~^shreg : ^shreg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ld_cfg     = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    dv_set     = 1'b0;
    pe_set     = 1'b0;
    se_set     = 1'b0;
    case (state)
      IDLE: begin
        if (start_det) next_state = START;
      end
      START: begin
        if (mid_tick) begin
          // A start bit that votes high was a glitch; drop it silently.
          if (maj) next_state = IDLE;
          else     ld_cfg = 1'b1;
        end else if (end_tick) begin
          next_state = DATA;
        end
      end
      DATA: begin
        if (end_tick) begin
          shift_en = 1'b1;
          if (bit_idx == BIT_LAST) next_state = par_en_l ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (end_tick) begin
          par_chk    = 1'b1;
          next_state = STOP;
        end
      end
      STOP: begin
        // Resolve at mid-stop so IDLE is re-entered early enough to catch
        // a start edge arriving right at the nominal stop end.
        if (mid_tick) begin
          next_state = IDLE;
          if (!maj)        se_set = 1'b1;
          else if (par_bad) pe_set = 1'b1;
          else             dv_set = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg     <= '0;
      bit_idx   <= '0;
      par_en_l  <= 1'b0;
      par_typ_l <= 1'b0;
      par_bad   <= 1'b0;
    end else begin
      if (start_det) begin
        bit_idx <= '0;
        par_bad <= 1'b0;
      end
      // Frame configuration is frozen at the start-bit midpoint.
      if (ld_cfg) begin
        par_en_l  <= PAR_EN;
        par_typ_l <= PAR_TYP;
      end
      if (shift_en) begin
        shreg   <= shreg_nxt;
        bit_idx <= bit_idx + 1'b1;
      end
      if (par_chk) par_bad <= (bit_val != par_exp);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STOP_ERR   <= 1'b0;
    end else begin
      DATA_VALID <= dv_set;
      PAR_ERR    <= pe_set;
      STOP_ERR   <= se_set;
      if (dv_set) P_DATA <= shreg;
    end
  end

  // Derived from the state register so it drops on the same edge the result pulse rises.
  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STOP_ERR;
  logic       Busy;

  uart_rx #(
    .CLK_freq    (1_600_000),
    .BAUD_RATE   (10_000),
    .P_data_width(8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STOP_ERR  (STOP_ERR),
    .Busy      (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam int K_VALID = 0;
  localparam int K_PERR  = 1;
  localparam int K_SERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   rd_idx;
  int   checks;
  int   errors;
  logic [7:0] last_good;
  time  fall_t;
  bit   lat_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Drives one frame; optionally inverts data bit spk_bit for one clock at spk_off.
  task automatic send(input logic [7:0] d, input bit pen, input bit pbit, input bit sbit,
                      input int bclk, input int spk_bit, input int spk_off);
    logic [10:0] fr;
    int n;
    fr = '0;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[i+1] = d[i];
    n = 9;
    if (pen) begin
      fr[n] = pbit;
      n++;
    end
    fr[n] = sbit;
    n++;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < bclk; c++) begin
        RX_IN = fr[b];
        if (b == spk_bit + 1 && c == spk_off) RX_IN = ~fr[b];
        if (b == 0 && c == 0) fall_t = $time;
        @(negedge CLK);
      end
    end
  endtask

  // Scoreboard side: pops an expectation for each result pulse.
  task automatic monitor();
    logic busy_prev;
    time  rise_t;
    int   n;
    int   kind;
    exp_t e;
    busy_prev = 1'b0;
    rise_t    = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        last_good = 8'h00;
        busy_prev = 1'b0;
      end else begin
        if (Busy && !busy_prev) begin
          rise_t = $time;
          if (lat_en) chk("det_lag", ((rise_t - fall_t) / 10 >= 2 && (rise_t - fall_t) / 10 <= 3), 1);
        end
        n = int'(DATA_VALID) + int'(PAR_ERR) + int'(STOP_ERR);
        if (n != 0) begin
          chk("one_pulse", n, 1);
          chk("busy_fall", Busy, 0);
          if (rd_idx >= exp_q.size()) begin
            chk("spurious_pulse", n, 0);
          end else begin
            e = exp_q[rd_idx];
            rd_idx++;
            kind = DATA_VALID ? K_VALID : (PAR_ERR ? K_PERR : K_SERR);
            chk("kind", kind, e.kind);
            if (e.kind == K_VALID) begin
              chk("data", P_DATA, e.data);
              last_good = e.data;
            end else begin
              chk("pdata_hold", P_DATA, last_good);
            end
            if (lat_en) begin
              chk("latency", (($time - rise_t) / 10 >= 1537 && ($time - rise_t) / 10 <= 1543), 1);
              lat_en = 1'b0;
            end
          end
        end
        busy_prev = Busy;
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] b2b [3];
    int   bclk [2];
    checks    = 0;
    errors    = 0;
    rd_idx    = 0;
    last_good = 8'h00;
    fall_t    = 0;
    lat_en    = 1'b0;
    RST       = 1'b1;
    RX_IN     = 1'b1;
    PAR_EN    = 1'b0;
    PAR_TYP   = 1'b0;

    fork
      monitor();
      begin
        #2_000_000;
        chk("watchdog", 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(negedge CLK);
    chk("rst_pdata", P_DATA, 8'h00);
    chk("rst_dv", DATA_VALID, 0);
    chk("rst_perr", PAR_ERR, 0);
    chk("rst_serr", STOP_ERR, 0);
    chk("rst_busy", Busy, 0);
    RST = 1'b0;
    idle(50);

    // Plain frame with latency check.
    lat_en = 1'b1;
    push(K_VALID, 8'hA5);
    send(8'hA5, 1'b0, 1'b0, 1'b1, 160, -5, 0);
    idle(400);
    chk("lat_checked", lat_en, 0);

    // Parity: even/ok, even/bad, odd/ok.
    PAR_EN = 1'b1;
    for (int t = 0; t < 3; t++) begin
      logic pb;
      PAR_TYP = (t == 2);
      pb      = (t != 0);
      push((pb == (^8'hA5 ^ PAR_TYP)) ? K_VALID : K_PERR, 8'hA5);
      send(8'hA5, 1'b1, pb, 1'b1, 160, -5, 0);
      idle(400);
    end
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;

    // Framing error, line held low, then a clean frame.
    push(K_SERR, 8'h3C);
    send(8'h3C, 1'b0, 1'b0, 1'b0, 160, -5, 0);
    RX_IN = 1'b0;
    repeat (320) @(negedge CLK);
    idle(320);
    push(K_VALID, 8'h81);
    send(8'h81, 1'b0, 1'b0, 1'b1, 160, -5, 0);
    idle(400);

    // Short low glitch on an idle line.
    RX_IN = 1'b0;
    repeat (40) @(negedge CLK);
    chk("glitch_busy", Busy, 1);
    RX_IN = 1'b1;
    repeat (280) @(negedge CLK);
    chk("glitch_idle", Busy, 0);
    idle(100);

    // Single-clock spikes at the vote points; majority must hold.
    push(K_VALID, 8'h00);
    send(8'h00, 1'b0, 1'b0, 1'b1, 160, 2, 80);
    idle(300);
    push(K_VALID, 8'hFF);
    send(8'hFF, 1'b0, 1'b0, 1'b1, 160, 3, 90);
    idle(300);
    push(K_VALID, 8'h00);
    send(8'h00, 1'b0, 1'b0, 1'b1, 160, 5, 100);
    idle(300);

    // Back-to-back frames at both tolerance extremes.
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h55;
    bclk[0] = 155;
    bclk[1] = 165;
    for (int r = 0; r < 2; r++) begin
      for (int f = 0; f < 3; f++) push(K_VALID, b2b[f]);
      for (int f = 0; f < 3; f++) send(b2b[f], 1'b0, 1'b0, 1'b1, bclk[r], -5, 0);
      idle(400);
    end

    // Reset during data bit 4.
    d = 8'h77;
    RX_IN = 1'b0;
    repeat (160) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RX_IN = d[i];
      repeat (160) @(negedge CLK);
    end
    RX_IN = d[4];
    repeat (80) @(negedge CLK);
    chk("busy_mid", Busy, 1);
    RST = 1'b1;
    #1;
    chk("arst_pdata", P_DATA, 8'h00);
    chk("arst_dv", DATA_VALID, 0);
    chk("arst_perr", PAR_ERR, 0);
    chk("arst_serr", STOP_ERR, 0);
    chk("arst_busy", Busy, 0);
    RX_IN = 1'b1;
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    idle(100);
    push(K_VALID, 8'h5A);
    send(8'h5A, 1'b0, 1'b0, 1'b1, 160, -5, 0);
    idle(100);

    for (int w = 0; w < 4000 && rd_idx < exp_q.size(); w++) @(negedge CLK);
    chk("pending", exp_q.size() - rd_idx, 0);
    chk("final_pdata", P_DATA, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that recovers the serial frame produced by the team's UART transmitter and presents it as a parallel word with a one-cycle valid strobe. It sits between the board RX pin and user logic on the master clock domain. It uses 16x oversampling, mid-bit majority voting, optional parity checking (same PAR_EN/PAR_TYP convention as the transmitter) and stop-bit (framing) checking.

## Interface
- CLK_freq, 100_000_000: master clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate.
- P_data_width, 8: data bits per frame.
- OS_TICKS, CLK_freq/(BAUD_RATE*16): master clocks per oversample tick. Derived; do not override. Must be ≥ 1.

- CLK  in  1  master clock; all logic on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- RX_IN  in  1  serial line, idle high, LSB first; asynchronous to CLK.
- PAR_EN  in  1  parity bit present in frame (1 = yes).
- PAR_TYP  in  1  0 = even, 1 = odd. Sampled at the start-bit midpoint.
- P_DATA  out  P_data_width  last correctly received word.
- DATA_VALID  out  1  one-CLK pulse when P_DATA is updated.
- PAR_ERR  out  1  one-CLK pulse: parity mismatch.
- STOP_ERR  out  1  one-CLK pulse: stop bit sampled low.
- Busy  out  1  high from start-edge detection until the frame is resolved.

## Operation
- RX_IN passes through a 2-flop synchronizer. A reset preset drives both flops to 1. All logic uses the synchronized value rx_s and its previous value rx_d.
- Prescaler counts 0..OS_TICKS-1 and emits a tick at terminal count. It restarts at 0 on start-edge detection.
- The sample counter (4 bits, 0..15) advances once per tick. Samples taken at counts 7, 8 and 9 feed a 2-of-3 majority vote that gives the bit value. A bit ends at count 15; the counter wraps to 0.
- FSM states:
  - IDLE:
    - Busy = 0.
    - When rx_d = 1 and rx_s = 0 (falling edge): clear the counters, go to START, set Busy = 1.
  - START:
    - Majority = 1 (glitch): return to IDLE with no error pulse.
    - Otherwise: latch PAR_EN/PAR_TYP and go to DATA at end of bit.
  - DATA:
    - Shift the majority bit into the MSB of a shift register on each bit end (LSB first on the wire).
    - After P_data_width bits, go to PARITY if the latched PAR_EN = 1, else go to STOP.
  - PARITY:
    - Expected bit = ^data for even, ~^data for odd.
    - Record a mismatch flag and go to STOP at end of bit.
  - STOP:
    - Resolve the frame on the count-9 tick, without waiting for the bit end, then go to IDLE.
    - Stop majority = 0: pulse STOP_ERR only. Parity is not reported and P_DATA is unchanged.
    - Else, mismatch flag set: pulse PAR_ERR; P_DATA is unchanged.
    - Else: load P_DATA and pulse DATA_VALID.
- Exactly one of DATA_VALID, PAR_ERR or STOP_ERR pulses per frame that passes START.
- The IDLE falling-edge rule means a stuck-low line after STOP_ERR is not taken as a new start until the line returns high and falls again.
- Unreachable state encodings go to IDLE on the next clock.

## Timing
- Reset values:
  - P_DATA = 0, DATA_VALID = 0, PAR_ERR = 0, STOP_ERR = 0, Busy = 0.
  - FSM in IDLE, counters at 0, synchronizer flops = 1.
- RST asserted mid-frame: abort immediately with no pulses. The frame is lost.
- Edge detection lags RX_IN by 2–3 CLK (synchronizer).
- Result pulse latency from the detected start edge: (1 + P_data_width + PAR_EN) × 16 × OS_TICKS + 10 × OS_TICKS clocks, ±1 CLK.
- Pulses are one CLK wide. Busy falls on the same edge the pulse rises.
- P_DATA is stable from the DATA_VALID edge until the next DATA_VALID.
- Back-to-back frames: IDLE is re-entered about 6 ticks before the nominal stop end. A start edge arriving at the nominal stop end must be caught.
- Baud tolerance: ±3% total mismatch must still decode correctly.
- PAR_EN/PAR_TYP changes mid-frame have no effect on the current frame.

## Test plan
Bench parameters: CLK_freq = 1_600_000, BAUD_RATE = 10_000, so OS_TICKS = 10 and one bit = 160 CLK.

- Reset, PAR_EN = 0, send 0xA5 → DATA_VALID pulse once, P_DATA = 0xA5, no error pulses, latency 1540 ±3 CLK from the start edge.
- PAR_EN = 1, PAR_TYP = 0, send 0xA5 with parity 0 → P_DATA = 0xA5. Repeat with parity 1 → PAR_ERR pulse, P_DATA still 0xA5. Repeat with PAR_TYP = 1 and parity 1 → valid.
- Send 0x3C with the stop bit forced low → STOP_ERR pulse, no DATA_VALID, P_DATA unchanged. Hold the line low for 2 bit times, then send 0x81 normally → valid with 0x81, no spurious frame.
- 40-CLK low glitch on the idle line → no pulses, Busy returns to 0 within 2 bit times. 1-CLK spikes at samples 7/8/9 of a data bit → majority value wins.
- Back-to-back 0x00, 0xFF, 0x55 at baud +3% and −3% (bit = 155/165 CLK) → three DATA_VALID pulses in order with correct data.
- Assert RST during data bit 4 of a frame → outputs go to reset values immediately. Next frame 0x5A after RST release → valid with 0x5A.
